tx_rr_arbiter: RTL
==================

TX_RR_ARBITER -- requirements
Module: tx_rr_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning payload width in bits.
REQ-002 SHALL have parameter NREQ, default 4, meaning requester count (legal range 2..8).
REQ-003 SHALL have port ACLK  input  1  channel clock; all logic is on the rising edge.
REQ-004 SHALL have port ARESETn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port req  input  NREQ  per-requester transfer request, level.
REQ-006 SHALL have port req_data  input  NREQ x WIDTH  per-requester staged payload.
REQ-007 SHALL have port ack  output  NREQ  one-hot pulse: this requester's payload is captured this cycle.
REQ-008 SHALL have port VALID  output  1  bus valid.
REQ-009 SHALL have port READY  input  1  bus ready from the receiver.
REQ-010 SHALL have port xDATA  output  WIDTH  bus payload.
REQ-011 SHALL have port owner  output  clog2(NREQ)  index of the requester whose payload is on xDATA.
REQ-012 SHALL have port busy  output  1  high while the state is SEND.

Function
REQ-013 SHALL implement two states: IDLE (VALID=0) and SEND (VALID=1).
REQ-014 SHALL drive VALID, xDATA and owner from registers only; no combinational path from READY or req to the bus outputs.
REQ-015 SHALL select a winner when a load occurs, using round-robin priority that starts at (last_owner+1) mod NREQ and searches upward with wrap-around.
REQ-016 SHALL, on a load, capture req_data[winner] into xDATA and winner into owner, pulse ack[winner] for exactly one cycle, and move to or stay in SEND.
REQ-017 SHALL perform a load in IDLE whenever any req bit is high; VALID therefore rises 1 cycle after req.
REQ-018 SHALL hold VALID, xDATA and owner stable in SEND while READY=0, with no timeout.
REQ-019 SHALL, on the handshake (VALID&READY), set last_owner=owner, then load the next winner in the same cycle if any req is high, otherwise go to IDLE; back-to-back transfers sustain 1 transfer/cycle.
REQ-020 SHALL never deassert VALID in SEND before the handshake, even if the owning requester drops req.
REQ-021 SHALL treat a requester as serviced on its ack; a requester keeping req high after ack is re-arbitrated as a new request.
REQ-022 SHALL keep ack all-zero in every cycle without a load, and never assert more than one ack bit.
REQ-023 SHALL NOT depend on the READY value while in IDLE (READY-before-VALID is legal).

Reset
REQ-024 SHALL, while ARESETn=0, force state=IDLE, VALID=0, xDATA=0, owner=0, ack=0, busy=0, and last_owner=NREQ-1 so that requester 0 has first priority.
REQ-025 SHALL abandon any in-flight transfer on reset assertion mid-SEND, with no ack replay after reset.
REQ-026 SHALL NOT perform a load in the first cycle after reset release; arbitration begins on the second ACLK edge after release.

Configuration
REQ-027 SHALL, when TX_ARB_LOCK_EN is defined, add port lock  input  NREQ, where lock[owner] high at the handshake forces the next load to select owner if req[owner] is high, bypassing round-robin.
REQ-028 SHALL, when TX_ARB_LOCK_EN is defined, leave last_owner unchanged during locked transfers.
REQ-029 SHALL, when TX_ARB_LOCK_EN is undefined, omit the lock port and use pure round-robin.

Structure
REQ-030 SHALL place the state enum (IDLE, SEND) and the NREQ default constant in shared package axi_arb_pkg.
REQ-031 SHALL implement winner selection in one combinational sub-module rr_picker with inputs req and last_owner, and outputs any and winner.

Verification
REQ-032 SHALL cover: reset, then req=4'b0001, READY=1 -> ack=0001 one cycle later, then VALID=1 with xDATA=req_data[0] and owner=0, handshake on the next cycle.
REQ-033 SHALL cover: req=4'b1111 held, READY=1 -> owner sequence 0,1,2,3,0 on consecutive cycles with VALID continuously high.
REQ-034 SHALL cover: req=4'b0100 with data 8'hA5, READY=0 for 5 cycles -> VALID=1 and xDATA=8'hA5 stable for 5 cycles, a single ack, and handshake on the cycle READY=1.
REQ-035 SHALL cover: ARESETn pulsed low mid-SEND -> VALID=0 immediately (asynchronously), and requester 0 wins the first load after reset despite req=4'b1010|0001.
REQ-036 SHALL cover, with TX_ARB_LOCK_EN: lock[2]=1, req=4'b1111, READY=1 -> owner=2 repeated until lock[2]=0, then the next owner is 3.
REQ-037 SHALL cover: after owner=3 completes, req=4'b1001 -> next owner=0 (wrap-around).

Source files
------------

// File: rtl/axi_arb_pkg.sv
// Shared types and defaults for the transmit round-robin arbiter.
// Holds the channel state encoding and the default requester count.
package axi_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } arb_state_t;

   localparam int NREQ_DEF  = 4;
   localparam int WIDTH_DEF = 8;

endpackage

// File: rtl/rr_picker.sv
// Round-robin winner search, purely combinational.
// Ports: req (requests), last_owner (previous grant) -> any, winner.
module rr_picker
   import axi_arb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] last_owner,
   output logic                    any,
   output logic [$clog2(NREQ)-1:0] winner
);

   localparam int IW = $clog2(NREQ);

   // Walk offsets from farthest to nearest so the
   // nearest requester after last_owner is written last.
   always_comb begin
      int idx;
      any    = 1'b0;
      winner = '0;
      idx    = 0;
      for (int i = NREQ; i >= 1; i--) begin
         idx = (int'(last_owner) + i) % NREQ;
         if (req[IW'(idx)]) begin
            any    = 1'b1;
            winner = IW'(idx);
         end
      end
   end

endmodule

// File: rtl/tx_rr_arbiter.sv
// Round-robin transmit arbiter driving a registered VALID/READY bus.
// Ports: ACLK, ARESETn, req, req_data, ack, VALID, READY, xDATA, owner,
// busy; lock only when TX_ARB_LOCK_EN is defined.
module tx_rr_arbiter
   import axi_arb_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int NREQ  = NREQ_DEF
) (
   input  logic                    ACLK,
   input  logic                    ARESETn,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*WIDTH-1:0]   req_data,
   output logic [NREQ-1:0]         ack,
   output logic                    VALID,
   input  logic                    READY,
`ifdef TX_ARB_LOCK_EN
   input  logic [NREQ-1:0]         lock,
`endif
   output logic [WIDTH-1:0]        xDATA,
   output logic [$clog2(NREQ)-1:0] owner,
   output logic                    busy
);

   localparam int IW = $clog2(NREQ);

   arb_state_t       state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [IW-1:0]    owner_q, owner_d;
   logic [IW-1:0]    last_q, last_d;
   logic [IW-1:0]    base, pick_w, sel;
   logic             pick_any, arm_q;
   logic             hs, locked, load;
   logic [WIDTH-1:0] slot [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_slot
      assign slot[g] = req_data[g*WIDTH +: WIDTH];
   end

   // A load in SEND only happens on the handshake, where the
   // finishing owner becomes last_owner in that same cycle.
   assign base = (state_q == SEND) ? owner_q : last_q;

   rr_picker #(
      .NREQ(NREQ)
   ) u_pick (
      .req       (req),
      .last_owner(base),
      .any       (pick_any),
      .winner    (pick_w)
   );

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      owner_d = owner_q;
      last_d  = last_q;
      ack     = '0;
      hs      = (state_q == SEND) && READY;
      locked  = 1'b0;
`ifdef TX_ARB_LOCK_EN
      locked  = hs && lock[owner_q] && req[owner_q];
`endif
      sel     = locked ? owner_q : pick_w;
      // arm_q holds off the very first edge after reset release.
      load    = arm_q && (locked || pick_any) &&
                ((state_q == IDLE) || hs);
      if (hs) begin
         state_d = IDLE;
         if (!locked) begin
            last_d = owner_q;
         end
      end
      if (load) begin
         state_d = SEND;
         data_d  = slot[sel];
         owner_d = sel;
         ack     = NREQ'(1) << sel;
      end
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q <= IDLE;
         data_q  <= '0;
         owner_q <= '0;
         last_q  <= IW'(NREQ - 1);
         arm_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         arm_q   <= 1'b1;
      end
   end

   assign VALID = (state_q == SEND);
   assign busy  = (state_q == SEND);
   assign xDATA = data_q;
   assign owner = owner_q;

endmodule
